// File: rtl/noc_xbar_switch_if.sv
// noc_xbar_switch_if: per-port packet handshake bundle of the crossbar switch
interface noc_xbar_switch_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 4
);
  localparam int ID_W  = $clog2(N_PORTS);
  localparam int PKT_W = 2 * ID_W + DATA_W;
  logic [N_PORTS-1:0]       in_valid, in_ready, out_valid, out_ready, busy;
  logic [N_PORTS*PKT_W-1:0] in_data, out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/noc_xbar_switch.sv
// noc_xbar_switch: N-port crossbar with per-input FIFOs, per-output round-robin
// arbiters and a registered valid/ready stage on every output
module noc_xbar_switch #(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
)(
  input logic clk,
  input logic rst,
  noc_xbar_switch_if.slave bus
);
  localparam int ID_W  = $clog2(N_PORTS);
  localparam int PKT_W = 2 * ID_W + DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  logic [PKT_W-1:0] mem [N_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [N_PORTS];
  logic [PTR_W-1:0] wr_ptr [N_PORTS];
  logic [CNT_W-1:0] count [N_PORTS];
  logic [ID_W-1:0]  rr_ptr [N_PORTS];
  logic [ID_W-1:0]  gnt_idx [N_PORTS];
  logic [PKT_W-1:0] head [N_PORTS];
  logic [PKT_W-1:0] out_q [N_PORTS];
  logic [N_PORTS-1:0] req [N_PORTS];
  logic [N_PORTS-1:0] push, pop, nonempty, free, gnt_vld, out_valid;
  logic [ID_W-1:0] idx;
  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign head[g]         = mem[g][rd_ptr[g]];
    assign nonempty[g]     = count[g] != '0;
    assign bus.in_ready[g] = rst && count[g] != FULL;
    assign push[g]         = bus.in_valid[g] && bus.in_ready[g];
    assign free[g]         = !out_valid[g] || bus.out_ready[g];
    assign bus.busy[g]     = nonempty[g] || out_valid[g];
    assign bus.out_data[g*PKT_W +: PKT_W] = out_q[g];
    // req[output][input]: input head is addressed to this output
    for (genvar h = 0; h < N_PORTS; h++) begin : g_req
      assign req[g][h] = nonempty[h] && head[h][DATA_W+ID_W-1 -: ID_W] == ID_W'(g);
    end
  end
  assign bus.out_valid = out_valid;
  // Each input head names one output, so at most one arbiter pops any input.
  always_comb begin
    gnt_vld = '0;
    pop     = '0;
    idx     = '0;
    for (int d = 0; d < N_PORTS; d++) begin
      gnt_idx[d] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = rr_ptr[d] + ID_W'(k);
        if (free[d] && !gnt_vld[d] && req[d][idx]) begin
          gnt_vld[d] = 1'b1;
          gnt_idx[d] = idx;
        end
      end
      if (gnt_vld[d]) pop[gnt_idx[d]] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PORTS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        rr_ptr[i] <= '0;
        out_q[i]  <= '0;
      end
      out_valid <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        wr_ptr[i]    <= wr_ptr[i] + PTR_W'(push[i]);
        rd_ptr[i]    <= rd_ptr[i] + PTR_W'(pop[i]);
        count[i]     <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        rr_ptr[i]    <= gnt_vld[i] ? gnt_idx[i] + ID_W'(1) : rr_ptr[i];
        out_q[i]     <= gnt_vld[i] ? head[gnt_idx[i]] : out_q[i];
        out_valid[i] <= gnt_vld[i] || (out_valid[i] && !bus.out_ready[i]);
      end
    end
  end
  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= bus.in_data[i*PKT_W +: PKT_W];
  end
endmodule

// File: doc/noc_xbar_switch.md
# noc_xbar_switch

Parametrised N-port packet switch that replaces the fixed 4-PE arbiter/router/shared-FIFO fabric of the NoC top level. It sits between the processing elements and the rest of the NoC. Each port has its own input FIFO, and each output port has its own round-robin arbiter, so up to N disjoint transfers complete per cycle. Every port has a registered valid/ready output stage. Packets use the existing {src, dest, data} format and pass through unmodified.

## Interface
Parameters:
- N_PORTS, 4: number of ports; power of two, 2..16.
- DATA_W, 4: payload width.
- FIFO_DEPTH, 4: entries per input FIFO; power of two, at least 2.
- ID_W (localparam): clog2(N_PORTS).
- PKT_W (localparam): 2*ID_W + DATA_W. Packet layout is src [PKT_W-1 -: ID_W], dest [DATA_W+ID_W-1 -: ID_W], data [DATA_W-1:0].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  N_PORTS  per-port packet valid.
- in_data  in  N_PORTS*PKT_W  port p occupies [p*PKT_W +: PKT_W].
- in_ready  out  N_PORTS  per-port input FIFO not full.
- out_valid  out  N_PORTS  per-port output register holds a packet.
- out_data  out  N_PORTS*PKT_W  same packing as in_data.
- out_ready  in  N_PORTS  per-port downstream accept.
- busy  out  N_PORTS  port p's input FIFO is non-empty or out_valid[p] is 1.

## Operation
- Input accept:
  - A push happens when in_valid[p] & in_ready[p].
  - in_ready[p] = (count_p < FIFO_DEPTH) and rst deasserted.
  - A push into a full FIFO is never accepted, even if a pop occurs in the same cycle.
- FIFO: circular buffer with rd/wr pointers and a count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Request: input i requests output d when FIFO i is non-empty and its head dest field equals d. Any dest value is legal, including dest == i (self-route).
- Output free: output d is free when out_valid[d] is 0, or out_valid[d] & out_ready[d].
- Arbitration, per output d, when free and requested:
  - Grant the requester with the lowest index at or above rr_ptr[d], wrapping modulo N_PORTS.
  - On a grant, rr_ptr[d] becomes (grant+1) mod N_PORTS. With no grant, rr_ptr[d] holds.
- Transfer on grant: the head of the granted FIFO is popped and loaded into out_data[d], and out_valid[d] is set to 1.
- Output clear: if out_ready[d] & out_valid[d] and there is no new grant, out_valid[d] clears to 0. out_data[d] holds its last value.
- Exclusivity: each input head targets exactly one output, so an input is popped at most once per cycle and no input-side conflict arises.
- Ordering: packets from one input to one output are delivered in FIFO order. There is no ordering guarantee across different inputs.

## Timing
- Reset (rst low, asynchronous), all of the following clear immediately:
  - all FIFOs empty, pointers and counts 0;
  - rr_ptr all 0;
  - out_valid 0 and out_data 0;
  - in_ready 0 and busy 0.
- The first accept is possible in the first cycle after rst rises.
- Reset asserted mid-operation discards all buffered and in-flight packets. No partial output is ever presented.
- Latency:
  - Packet accepted at edge k is visible at the FIFO head in cycle k+1.
  - An uncontended grant at edge k+1 gives out_valid=1 from k+1.
  - Minimum is two edges from accept to presentation.
- Throughput: one packet per output per cycle with out_ready held high. In steady state with no contention, one packet per input per cycle.
- Backpressure: while out_valid[d]=1 and out_ready[d]=0, out_data[d] and out_valid[d] hold stable, and requesting heads stay in their FIFOs.
- in_ready[p] falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from a full FIFO.

## Test plan
- Single packet: port 0 sends {src=0, dest=2, data=0xA} with out_ready all 1. out_valid[2]=1 with out_data[2]=0x2A exactly two edges after accept. No other out_valid asserts.
- Hotspot: ports 0, 1, 2 and 3 each send one packet to dest 3 in the same cycle, with out_ready[3]=1.
  - Deliveries occur on 4 consecutive cycles in order src 0, 1, 2, 3.
  - A second burst after that is served starting at src 0 again, because rr_ptr[3] wrapped to 0.
- Backpressure: hold out_ready[1]=0 and stream packets 1..6 from port 0 to dest 1, with FIFO_DEPTH=4.
  - in_ready[0] drops after 4 FIFO entries plus 1 in the output register.
  - After releasing out_ready, all 5 accepted packets arrive in order with none lost.
- Parallel disjoint: port i sends to dest (i+1) mod 4 on every cycle for 20 cycles. All 4 outputs deliver one packet per cycle in steady state, and all payloads match.
- Self-route and reset: port 2 sends to dest 2, then rst is pulsed low mid-stream.
  - out_valid and busy go 0 immediately, with no clock edge needed.
  - After release, a fresh packet again has 2-edge latency.
- N_PORTS=8, DATA_W=8, FIFO_DEPTH=8: randomised traffic checked against a scoreboard. Delivery is per-(src, dest) in order, with no loss or duplication, and no starvation beyond 7 grants.
